// File: rtl/register_file.sv
// register_file: 2**ADDR x N general-purpose register file with one
// synchronous write port and two combinational read ports.
// Register 0 is hardwired to zero; writes to it are dropped.
// All stored registers clear asynchronously while reset is high.
// Optional feature macro: REGISTER_FILE_WRITE_BYPASS_EN. When it is defined,
// a read port whose address matches the pending write shows the write data
// before the clock edge. Reset and address 0 are excluded from forwarding.
module register_file #(
  parameter int N    = 32,
  parameter int ADDR = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Reg_Write_i,
  input  logic [ADDR-1:0] Write_Register_i,
  input  logic [N-1:0]    Write_Data_i,
  input  logic [ADDR-1:0] Read_Register_1_i,
  input  logic [ADDR-1:0] Read_Register_2_i,
  output logic [N-1:0]    Read_Data_1_o,
  output logic [N-1:0]    Read_Data_2_o
);

  localparam int DEPTH = 2 ** ADDR;

  // Flattened view of every register, including the constant zero at index 0.
  // Each element has exactly one driver: either a constant or one generate slot.
  logic [DEPTH-1:0][N-1:0] regs;

  // Address decode shared by all slots.
  // Reset blocks writes even though the stored flops are already clearing.
  logic write_ok;
  assign write_ok = Reg_Write_i && !reset;

  // Register 0 never holds state.
  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [N-1:0] q;
      logic         hit;

      assign hit = write_ok && (Write_Register_i == ADDR'(gi));

      // Storage slot: asynchronous clear, load on an addressed write.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q <= '0;
        end else if (hit) begin
          q <= Write_Data_i;
        end
      end

      assign regs[gi] = q;
    end
  endgenerate

  // Raw array lookups for each read port.
  // Stored registers are zero during reset, so these also read zero then.
  logic [N-1:0] array_data_1;
  logic [N-1:0] array_data_2;
  assign array_data_1 = regs[Read_Register_1_i];
  assign array_data_2 = regs[Read_Register_2_i];

`ifdef REGISTER_FILE_WRITE_BYPASS_EN
  // Forward the pending write to a matching read port.
  // Address 0 is excluded so that it stays hardwired to zero.
  // The reset term is folded into write_ok, so forwarding is also off during reset.
  logic fwd_valid;
  logic fwd_1;
  logic fwd_2;
  assign fwd_valid = write_ok && (Write_Register_i != '0);
  assign fwd_1     = fwd_valid && (Write_Register_i == Read_Register_1_i);
  assign fwd_2     = fwd_valid && (Write_Register_i == Read_Register_2_i);

  // Read mux: the forwarded data takes precedence over the stored contents.
  always_comb begin
    Read_Data_1_o = fwd_1 ? Write_Data_i : array_data_1;
    Read_Data_2_o = fwd_2 ? Write_Data_i : array_data_2;
  end
`else
  // Read mux: stored contents only.
  // A same-cycle write becomes visible after the clock edge.
  always_comb begin
    Read_Data_1_o = array_data_1;
    Read_Data_2_o = array_data_2;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table vectors, directed corner sequences and random
// traffic for register_file. It is checked against an array-based model that
// understands the optional write bypass (REGISTER_FILE_WRITE_BYPASS_EN).
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  register_file #(.N(32), .ADDR(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (we),
    .Write_Register_i  (waddr),
    .Write_Data_i      (wdata),
    .Read_Register_1_i (ra1),
    .Read_Register_2_i (ra2),
    .Read_Data_1_o     (rd1),
    .Read_Data_2_o     (rd2)
  );

  always #5 clk = ~clk;

  // Expected combinational read value, derived from the behavioural rules.
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (reset) return 32'h0;
    if (a == 5'd0) return 32'h0;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model[a];
  endfunction

  // Apply the effect of a rising clock edge to the model.
  task automatic commit();
    if (!reset && we && waddr != 5'd0) model[waddr] = wdata;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_ports(input string name);
    check({name, " p1"}, rd1, ref_read(ra1));
    check({name, " p2"}, rd2, ref_read(ra2));
  endtask

  // One write/read cycle: drive at negedge, check before and after the edge.
  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input string tag);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; ra1 = a1; ra2 = a2;
    #1;
    check_ports({tag, " pre"});
    @(posedge clk);
    commit();
    #1;
    check_ports({tag, " post"});
    $display("%s: we=%0b wa=%0d wd=%h ra1=%0d rd1=%h ra2=%0d rd2=%h",
             tag, w, wa, wd, a1, rd1, a2, rd2);
  endtask

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // Post-edge expectations, derived by hand from a cleared file.
    vecs[0] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd0,  32'hA5A5A5A5, 32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h0,        32'hA5A5A5A5};
    vecs[2] = '{1'b0, 5'd3,  32'hDEADBEEF, 5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[3] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd3,  32'h00000001, 32'hA5A5A5A5};
    vecs[4] = '{1'b1, 5'd3,  32'h00000000, 5'd3,  5'd31, 32'h0,        32'h00000001};
    vecs[5] = '{1'b1, 5'd16, 32'hCAFEF00D, 5'd16, 5'd16, 32'hCAFEF00D, 32'hCAFEF00D};

    clear_model();

    // Initial reset: outputs zero while reset is held.
    #3 reset = 1'b1;
    ra1 = 5'd0; ra2 = 5'd31;
    #1;
    check("reset a0", rd1, 32'h0);
    check("reset a31", rd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      we = vecs[i].w; waddr = vecs[i].wa; wdata = vecs[i].wd;
      ra1 = vecs[i].a1; ra2 = vecs[i].a2;
      @(posedge clk);
      commit();
      #1;
      check($sformatf("vec%0d p1", i), rd1, vecs[i].e1);
      check($sformatf("vec%0d p2", i), rd2, vecs[i].e2);
      $display("vec%0d: we=%0b wa=%0d wd=%h rd1=%h rd2=%h", i, vecs[i].w, vecs[i].wa,
               vecs[i].wd, rd1, rd2);
    end

    // Fill: a reset pulse, then one random word per address.
    @(negedge clk);
    we = 1'b0;
    reset = 1'b1; #1 reset = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) cycle(1'b1, 5'(i), $urandom, 5'(i), 5'(i), $sformatf("fill%0d", i));
    @(negedge clk);
    we = 1'b0;

    // Dual read sweep: both ports move every 1 ns, with no writes.
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check_ports($sformatf("sweep%0d", i));
    end
    $display("sweep: dual-port read of 32 addresses done");

    // Asynchronous reset pulse away from any clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check($sformatf("areset%0d p1", i), rd1, 32'h0);
      check($sformatf("areset%0d p2", i), rd2, 32'h0);
    end
    $display("areset: 1 ns pulse cleared all addresses");

    // Write enable low: nothing may change.
    for (int i = 1; i < 32; i++) cycle(1'b0, 5'(i), 32'hDEADBEEF, 5'(i), 5'(i), $sformatf("nowe%0d", i));
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); ra1 = 5'(i); ra2 = 5'(i); #1;
      check($sformatf("nowe_rd%0d", i), rd1, 32'h0);
    end

    // Register zero discards writes, with or without bypass.
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "reg0");
    check("reg0 direct", rd2, 32'h0);

    // Same-cycle write and read at address 5.
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; ra1 = 5'd5; ra2 = 5'd5;
    #1;
`ifdef REGISTER_FILE_WRITE_BYPASS_EN
    check("same5 pre p1", rd1, 32'h12345678);
    check("same5 pre p2", rd2, 32'h12345678);
`else
    check("same5 pre p1", rd1, 32'h0);
    check("same5 pre p2", rd2, 32'h0);
`endif
    @(posedge clk);
    commit();
    #1;
    check("same5 post p1", rd1, 32'h12345678);
    check("same5 post p2", rd2, 32'h12345678);
    $display("same5: rd1=%h rd2=%h after edge", rd1, rd2);

    // Reset priority over a simultaneous write, then the first write afterwards.
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h77777777; ra1 = 5'd7; ra2 = 5'd5;
    reset = 1'b1;
    clear_model();
    #1;
    check("rstpri pre p1", rd1, 32'h0);
    check("rstpri pre p2", rd2, 32'h0);
    @(posedge clk);
    #1;
    check("rstpri edge p1", rd1, 32'h0);
    check("rstpri edge p2", rd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_ports("rstrel pre");
    @(posedge clk);
    commit();
    #1;
    check("rstrel post p1", rd1, 32'h77777777);
    check("rstrel post p2", rd2, 32'h0);
    $display("rstpri: write blocked during reset, rd1=%h after release", rd1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $sformatf("rnd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
